// File: rtl/touch_key_pkg.sv
// touch_key_pkg: shared state encoding, default timing parameters and counter sizing
package touch_key_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC = 0;
  function automatic int cnt_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus consecutive-cycle counter debouncer
module key_debounce
  import touch_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_raw,
  output logic stable
);
  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  logic s1_q, s2_q, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    stable_d = (s2_q != stable_q && cnt_q == CNT_LAST) ? s2_q : stable_q;
    cnt_d = (s2_q == stable_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= pad_raw;
      s2_q <= s1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable = stable_q;
endmodule

// File: rtl/touch_key_tx.sv
// touch_key_tx: debounced touch key with momentary/toggle press FSM and max-hold lockout
module touch_key_tx
  import touch_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter bit TOGGLE_MODE = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic pad_raw,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic timeout_flag
);
  localparam int HW = cnt_width(TIMEOUT_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = '1;
  logic stable;
  state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic key_q, key_d, press_q, press_d, rel_q, rel_d, to_q, to_d;
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clk(sys_clk),
    .rst(rst),
    .pad_raw(pad_raw),
    .stable(stable)
  );
  always_comb begin
    state_d = state_q;
    hold_d = '0;
    key_d = key_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    to_d = to_q;
    case (state_q)
      IDLE: if (stable) begin
        state_d = PRESSED;
        press_d = 1'b1;
        key_d = TOGGLE_MODE ? ~key_q : 1'b1;
      end
      PRESSED: if (!stable) begin
        state_d = IDLE;
        rel_d = 1'b1;
        key_d = TOGGLE_MODE ? key_q : 1'b0;
      end else if (TIMEOUT_CYC != 0 && hold_q == HOLD_LAST) begin
        state_d = LOCKOUT;
        key_d = 1'b0;
        to_d = 1'b1;
      end else begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      end
      LOCKOUT: if (!stable) begin
        state_d = IDLE;
        rel_d = 1'b1;
        to_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      key_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      key_q <= key_d;
      press_q <= press_d;
      rel_q <= rel_d;
      to_q <= to_d;
    end
  end
  assign key_out = key_q;
  assign press_pulse = press_q;
  assign release_pulse = rel_q;
  assign timeout_flag = to_q;
endmodule

// File: tb/tb_touch_key_tx.sv
// tb_touch_key_tx: scoreboard bench over momentary, toggle and no-timeout instances
module tb_touch_key_tx;
  localparam int D = 8;
  typedef struct {int cyc; logic [3:0] v;} ev_t;
  logic clk, rst, pad_raw;
  logic [2:0] key, prs, rls, tof;
  int checks = 0, failures = 0, cyc = -1;
  bit mon_on = 0;
  ev_t sb[3][$];
  bit hist[$];
  int tcfg[3] = '{64, 64, 0};
  bit tgl[3] = '{1'b0, 1'b1, 1'b0};
  int phase[3], press_edge[3];
  bit mkey[3], mp[3], mr[3], mto[3], stable_m;
  logic [3:0] last_exp[3], dprev[3];
  int last_press[3], last_rel[3], last_to[3], presses[3], releases[3], to_rises[3];
  touch_key_tx #(.DEBOUNCE_CYC(D), .TIMEOUT_CYC(64), .TOGGLE_MODE(1'b0)) u_mom (
    .sys_clk(clk), .rst(rst), .pad_raw(pad_raw), .key_out(key[0]),
    .press_pulse(prs[0]), .release_pulse(rls[0]), .timeout_flag(tof[0]));
  touch_key_tx #(.DEBOUNCE_CYC(D), .TIMEOUT_CYC(64), .TOGGLE_MODE(1'b1)) u_tog (
    .sys_clk(clk), .rst(rst), .pad_raw(pad_raw), .key_out(key[1]),
    .press_pulse(prs[1]), .release_pulse(rls[1]), .timeout_flag(tof[1]));
  touch_key_tx #(.DEBOUNCE_CYC(D), .TIMEOUT_CYC(0), .TOGGLE_MODE(1'b0)) u_not (
    .sys_clk(clk), .rst(rst), .pad_raw(pad_raw), .key_out(key[2]),
    .press_pulse(prs[2]), .release_pulse(rls[2]), .timeout_flag(tof[2]));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic model_step(input bit r);
    bit ok;
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0;
      mr[i] = 0;
      if (r) begin
        phase[i] = 0;
        mkey[i] = 0;
        mto[i] = 0;
      end else if (phase[i] == 0) begin
        if (stable_m) begin
          phase[i] = 1;
          mp[i] = 1;
          mkey[i] = tgl[i] ? !mkey[i] : 1'b1;
          press_edge[i] = cyc;
        end
      end else if (phase[i] == 1) begin
        if (!stable_m) begin
          phase[i] = 0;
          mr[i] = 1;
          if (!tgl[i]) mkey[i] = 0;
        end else if (tcfg[i] != 0 && cyc - press_edge[i] == tcfg[i]) begin
          phase[i] = 2;
          mkey[i] = 0;
          mto[i] = 1;
        end
      end else if (!stable_m) begin
        phase[i] = 0;
        mr[i] = 1;
        mto[i] = 0;
      end
    end
    if (r) stable_m = 0;
    else if (cyc - 1 - D >= 0) begin
      ok = 1;
      for (int j = cyc - 2; j > cyc - 2 - D; j--) if (hist[j] == stable_m) ok = 0;
      if (ok) stable_m = !stable_m;
    end
    for (int i = 0; i < 3; i++) begin
      logic [3:0] v;
      v = {mkey[i], mp[i], mr[i], mto[i]};
      if (v != last_exp[i]) sb[i].push_back('{cyc, v});
      last_exp[i] = v;
    end
  endtask
  task automatic tick(input bit p, input bit r);
    @(negedge clk);
    pad_raw = p;
    rst = r;
    @(posedge clk);
    hist.push_back(p);
    cyc = hist.size() - 1;
    if (r) begin
      hist[cyc] = 0;
      if (cyc > 0) hist[cyc-1] = 0;
    end
    model_step(r);
    #1;
  endtask
  task automatic run(input bit p, input int n);
    repeat (n) tick(p, 0);
  endtask
  initial begin
    ev_t e;
    logic [3:0] v;
    forever begin
      @(negedge clk);
      if (mon_on) for (int i = 0; i < 3; i++) begin
        v = {key[i], prs[i], rls[i], tof[i]};
        if (v !== dprev[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb%0d_extra cyc=%0d got=%b want=none", i, cyc, v);
          end else begin
            e = sb[i].pop_front();
            chk($sformatf("sb%0d_cyc", i), cyc, e.cyc);
            chk($sformatf("sb%0d_vec@%0d", i, cyc), int'(v), int'(e.v));
          end
          if (prs[i]) begin last_press[i] = cyc; presses[i]++; end
          if (rls[i]) begin last_rel[i] = cyc; releases[i]++; end
          if (tof[i] && !dprev[i][0]) begin last_to[i] = cyc; to_rises[i]++; end
          dprev[i] = v;
        end else if (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
          e = sb[i].pop_front();
          chk($sformatf("sb%0d_missed", i), cyc, e.cyc);
        end
      end
    end
  end
  initial begin
    int n0, pb, rb, kv, len;
    bit lvl;
    pad_raw = 0;
    rst = 1;
    stable_m = 0;
    for (int i = 0; i < 3; i++) begin
      last_exp[i] = 0;
      dprev[i] = 0;
      phase[i] = 0;
    end
    repeat (3) tick(0, 1);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_vec%0d", i), int'({key[i], prs[i], rls[i], tof[i]}), 0);
    mon_on = 1;
    run(0, 5);
    n0 = cyc + 1;
    run(1, 40);
    chk("press_latency", last_press[0] - n0, D + 2);
    n0 = cyc + 1;
    run(0, 40);
    chk("release_latency", last_rel[0] - n0, D + 2);
    pb = presses[0];
    repeat (3) begin run(1, 5); run(0, 2); end
    n0 = cyc + 1;
    run(1, 30);
    chk("bounce_presses", presses[0] - pb, 1);
    chk("bounce_latency", last_press[0] - n0, D + 2);
    run(0, 30);
    pb = presses[0];
    rb = releases[0];
    run(1, 7);
    run(0, 20);
    chk("glitch7_press", presses[0] - pb, 0);
    chk("glitch7_key", int'(key[0]), 0);
    run(1, 8);
    run(0, 20);
    chk("glitch8_press", presses[0] - pb, 1);
    chk("glitch8_release", releases[0] - rb, 1);
    kv = int'(mkey[1]);
    for (int k = 0; k < 3; k++) begin
      run(1, 20);
      chk("toggle_after_press", int'(key[1]), 1 - kv);
      kv = 1 - kv;
      run(0, 20);
      chk("toggle_after_release", int'(key[1]), kv);
    end
    rb = releases[0];
    run(1, 100);
    chk("timeout_gap", last_to[0] - last_press[0], 64);
    chk("timeout_key", int'(key[0]), 0);
    chk("timeout_flag", int'(tof[0]), 1);
    chk("no_timeout_key", int'(key[2]), 1);
    chk("no_timeout_flag", int'(tof[2]), 0);
    run(0, 30);
    chk("timeout_cleared", int'(tof[0]), 0);
    chk("timeout_release", releases[0] - rb, 1);
    run(1, 20);
    tick(1, 1);
    for (int i = 0; i < 3; i++) chk($sformatf("midreset_vec%0d", i), int'({key[i], prs[i], rls[i], tof[i]}), 0);
    n0 = cyc + 1;
    run(1, 30);
    chk("reset_repress_latency", last_press[0] - n0, D + 2);
    run(0, 30);
    lvl = 0;
    repeat (150) begin
      lvl = !lvl;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 120) : $urandom_range(1, 24);
      if ($urandom_range(0, 39) == 0) tick(lvl, 1);
      run(lvl, len);
    end
    run(0, 40);
    for (int i = 0; i < 3; i++) chk($sformatf("sb%0d_drained", i), sb[i].size(), 0);
    chk("no_timeout_rises", to_rises[2], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
